// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI master transfer controller.
// Holds the FSM state encoding, default widths and the SCK edge count per word.
package spi_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int SPR_W_DEF  = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LEAD  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_TRAIL = 2'd3
  } spi_state_e;

  // One word takes two SCK edges per bit.
  function automatic int edge_count(input int data_w);
    return 2 * data_w;
  endfunction

  localparam int EDGE_CNT_DEF = 2 * DATA_W_DEF;

endpackage

// File: rtl/spi_baud_gen.sv
// Half-period tick generator: emits a one-cycle tick every 2^spr clk cycles while enabled.
// While disabled the counter is preloaded so the first tick arrives one half-period after enable.
module spi_baud_gen
  import spi_pkg::*;
#(
  parameter int SPR_W = SPR_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [SPR_W-1:0] spr,
  output logic             tick
);

  // Largest half-period is 2^(2^SPR_W - 1) cycles, so the down-counter needs 2^SPR_W - 1 bits.
  localparam int CNT_W = (1 << SPR_W) - 1;
  localparam logic [CNT_W-1:0] ONES = '1;
  localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic [CNT_W-1:0] reload;

  assign reload = ONES >> (CNT_W - int'(spr));
  assign tick   = en && (cnt_q == '0);

  always_comb begin
    cnt_d = cnt_q;
    if (!en || (cnt_q == '0)) begin
      cnt_d = reload;
    end else begin
      cnt_d = cnt_q - ONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/spi_xfer_ctrl.sv
// SPI master transfer controller: IDLE -> LEAD -> SHIFT -> TRAIL, CPOL/CPHA modes, sticky SPIF.
// Optional build macro SPI_LSBFE_EN adds an lsbfe input selecting LSB-first order.
module spi_xfer_ctrl
  import spi_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int SPR_W  = SPR_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mstr,
  input  logic              cpol,
  input  logic              cpha,
  input  logic [SPR_W-1:0]  spr,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic [DATA_W-1:0] rx_data,
  output logic              spif,
  input  logic              spif_clr,
  output logic              busy,
  output logic              sck_out,
  output logic              data_out,
  input  logic              data_in,
`ifdef SPI_LSBFE_EN
  input  logic              lsbfe,
`endif
  output logic              ss_master
);

  localparam int EDGES = edge_count(DATA_W);
  localparam int EC_W  = $clog2(EDGES + 1);

  spi_state_e        state_q;
  logic              cpol_q;
  logic              cpha_q;
  logic [SPR_W-1:0]  spr_q;
  logic              lsb_q;
  logic [DATA_W-1:0] tx_sh_q;
  logic [DATA_W-1:0] rx_sh_q;
  logic [DATA_W-1:0] rx_data_q;
  logic              spif_q;
  logic              sck_q;
  logic              dout_q;
  logic              ss_q;
  logic [EC_W-1:0]   ecnt_q;

  logic              lsb_acc;
  logic              tick;
  logic [SPR_W-1:0]  spr_sel;
  logic              sample_edge;
  logic              last_edge;
  logic [DATA_W-1:0] rx_shifted;

`ifdef SPI_LSBFE_EN
  assign lsb_acc = lsbfe;
`else
  assign lsb_acc = 1'b0;
`endif

  function automatic logic first_bit(input logic [DATA_W-1:0] w, input logic lsb);
    return lsb ? w[0] : w[DATA_W-1];
  endfunction

  function automatic logic [DATA_W-1:0] shift_out(input logic [DATA_W-1:0] w, input logic lsb);
    return lsb ? {1'b0, w[DATA_W-1:1]} : {w[DATA_W-2:0], 1'b0};
  endfunction

  function automatic logic [DATA_W-1:0] shift_in(input logic [DATA_W-1:0] w, input logic b,
                                                 input logic lsb);
    return lsb ? {b, w[DATA_W-1:1]} : {w[DATA_W-2:0], b};
  endfunction

  // The live spr preloads the counter while idle, so LEAD starts with the accepted rate.
  assign spr_sel = (state_q == ST_IDLE) ? spr : spr_q;

  spi_baud_gen #(
    .SPR_W (SPR_W)
  ) u_baud (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (state_q != ST_IDLE),
    .spr   (spr_sel),
    .tick  (tick)
  );

  // ecnt_q counts completed edges, so the edge about to happen is ecnt_q + 1.
  assign sample_edge = (ecnt_q[0] == cpha_q);
  assign last_edge   = (ecnt_q == EC_W'(EDGES - 1));
  assign rx_shifted  = shift_in(rx_sh_q, data_in, lsb_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      cpol_q    <= 1'b0;
      cpha_q    <= 1'b0;
      spr_q     <= '0;
      lsb_q     <= 1'b0;
      tx_sh_q   <= '0;
      rx_sh_q   <= '0;
      rx_data_q <= '0;
      spif_q    <= 1'b0;
      sck_q     <= 1'b0;
      dout_q    <= 1'b0;
      ss_q      <= 1'b1;
      ecnt_q    <= '0;
    end else begin
      if (spif_clr) begin
        spif_q <= 1'b0;
      end
      if ((state_q != ST_IDLE) && !mstr) begin
        state_q <= ST_IDLE;
        ss_q    <= 1'b1;
        sck_q   <= cpol;
      end else begin
        case (state_q)
          ST_IDLE: begin
            sck_q <= cpol;
            ss_q  <= 1'b1;
            if (tx_valid && tx_ready) begin
              state_q <= ST_LEAD;
              ss_q    <= 1'b0;
              cpol_q  <= cpol;
              cpha_q  <= cpha;
              spr_q   <= spr;
              lsb_q   <= lsb_acc;
              ecnt_q  <= '0;
              rx_sh_q <= '0;
              if (!cpha) begin
                dout_q  <= first_bit(tx_data, lsb_acc);
                tx_sh_q <= shift_out(tx_data, lsb_acc);
              end else begin
                tx_sh_q <= tx_data;
              end
            end
          end
          ST_LEAD: begin
            sck_q <= cpol_q;
            if (tick) begin
              state_q <= ST_SHIFT;
            end
          end
          ST_SHIFT: begin
            if (tick) begin
              sck_q  <= ~sck_q;
              ecnt_q <= ecnt_q + EC_W'(1);
              if (sample_edge) begin
                rx_sh_q <= rx_shifted;
              end else if (!last_edge) begin
                dout_q  <= first_bit(tx_sh_q, lsb_q);
                tx_sh_q <= shift_out(tx_sh_q, lsb_q);
              end
              if (last_edge) begin
                state_q   <= ST_TRAIL;
                rx_data_q <= sample_edge ? rx_shifted : rx_sh_q;
                spif_q    <= 1'b1;
              end
            end
          end
          ST_TRAIL: begin
            if (tick) begin
              state_q <= ST_IDLE;
              ss_q    <= 1'b1;
            end
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign tx_ready  = (state_q == ST_IDLE) && mstr;
  assign busy      = (state_q != ST_IDLE);
  assign rx_data   = rx_data_q;
  assign spif      = spif_q;
  assign sck_out   = sck_q;
  assign data_out  = dout_q;
  assign ss_master = ss_q;

endmodule

// File: doc/spi_xfer_ctrl.md
SPI_XFER_CTRL -- requirements
Module: spi_xfer_ctrl

Interface
REQ-001 SHALL have parameter DATA_W, default 8, transfer word width in bits.
REQ-002 SHALL have parameter SPR_W, default 3, baud-select field width.
REQ-003 SHALL have port clk, input, 1, single block clock.
REQ-004 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port mstr, input, 1, 1 = master mode, 0 = slave mode (block idle).
REQ-006 SHALL have port cpol, input, 1, SCK idle level.
REQ-007 SHALL have port cpha, input, 1, 0 = sample on odd edges, 1 = sample on even edges.
REQ-008 SHALL have port spr, input, SPR_W, half-period = 2^spr clk cycles.
REQ-009 SHALL have port tx_data, input, DATA_W, word to send.
REQ-010 SHALL have port tx_valid, input, 1, start request.
REQ-011 SHALL have port tx_ready, output, 1, high only in IDLE with mstr=1.
REQ-012 SHALL have port rx_data, output, DATA_W, last received word.
REQ-013 SHALL have port spif, output, 1, transfer-complete flag (sticky).
REQ-014 SHALL have port spif_clr, input, 1, clears spif.
REQ-015 SHALL have port busy, output, 1, high in any state other than IDLE.
REQ-016 SHALL have port sck_out, output, 1, to port logic SCK_out.
REQ-017 SHALL have port data_out, output, 1, to port logic Data_out (MOSI).
REQ-018 SHALL have port data_in, input, 1, from port logic Data_in (MISO).
REQ-019 SHALL have port ss_master, output, 1, to port logic SS_master, active low.

Function
REQ-020 SHALL implement FSM IDLE -> LEAD -> SHIFT -> TRAIL -> IDLE.
REQ-021 IDLE: accept on tx_valid && tx_ready; latch tx_data into the shift register; go to LEAD next cycle.
REQ-022 LEAD: ss_master=0 for one half-period; with cpha=0, the first bit is already on data_out.
REQ-023 SHIFT: toggle sck_out every half-period, for exactly 2*DATA_W edges.
REQ-024 cpha=0: sample data_in on odd edges, drive the next bit on even edges; cpha=1: drive on odd edges, sample on even edges.
REQ-025 After the final edge: go to TRAIL; hold ss_master=0 for one half-period; then IDLE with ss_master=1.
REQ-026 On entry to TRAIL: rx_data updates; spif sets in the same cycle.
REQ-027 spif_clr clears spif; simultaneous set and clear: set wins.
REQ-028 In IDLE and LEAD, sck_out SHALL equal cpol.
REQ-029 Default bit order is MSB first.
REQ-030 tx_valid while busy is ignored; no queuing.
REQ-031 mstr falling mid-transfer: next-cycle IDLE; ss_master=1; sck_out=cpol; no spif; rx_data unchanged.
REQ-032 cpol, cpha and spr are sampled at acceptance and held for the whole transfer.
REQ-033 The half-period counter is SPR_W+... wide enough for 2^(2^SPR_W-1); it reloads at each edge.

Reset
REQ-034 rst_n low: state=IDLE; ss_master=1; sck_out=0; data_out=0; rx_data=0; spif=0; busy=0; counters=0.
REQ-035 Reset asserted mid-transfer: abort immediately, with the above values, asynchronously.

Configuration
REQ-036 Macro SPI_LSBFE_EN defined: add input lsbfe (1 = LSB first), sampled at acceptance; rx_data is assembled in the same order.
REQ-037 Macro SPI_LSBFE_EN undefined: no lsbfe port; MSB first always.

Structure
REQ-038 Shared package spi_pkg SHALL hold the FSM state enum, DATA_W/SPR_W defaults and the edge-count constant.
REQ-039 Sub-module spi_baud_gen SHALL produce a one-cycle half-period tick from spr; the FSM stays in spi_xfer_ctrl.

Verification
REQ-040 mstr=1, cpol=0, cpha=0, spr=0, tx_data=0xA5, MISO loopback -> 16 sck edges 1 clk apart; rx_data=0xA5; spif=1; ss_master low 18 clk.
REQ-041 cpol=1, cpha=1, spr=2, tx_data=0x3C, MISO tied 1 -> sck idles high; edges 4 clk apart; rx_data=0xFF; data_out changes on odd edges.
REQ-042 tx_valid pulsed mid-transfer with 0x11 -> ignored; tx_ready=0; one transfer only.
REQ-043 spif_clr asserted in the spif-set cycle -> spif=1; spif_clr one cycle later -> spif=0.
REQ-044 mstr dropped after 5 edges -> next cycle IDLE; ss_master=1; sck_out=cpol; spif=0.
REQ-045 rst_n asserted after 9 edges -> all outputs at reset values, asynchronously; a new transfer then completes normally.
